// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: burst capture of AD9238 ch0/ch1 sample pairs into sample RAM.
// A start pulse launches a capture of DEPTH packed words written from BASE_ADDR,
// one word every dec+1 cycles; abort or completion returns to IDLE.
module adc_capture_ctrl #(
  parameter int                ADDR_W    = 13,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 13'h0400,
  parameter int                DEPTH     = 1024,
  parameter int                DEC_W     = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              csr_start_in,
  input  logic              csr_abort_in,
  input  logic [DEC_W-1:0]  csr_decim_in,
  input  logic [11:0]       ad9238_data_ch0,
  input  logic [11:0]       ad9238_data_ch1,
  output logic [ADDR_W-1:0] adc_addr,
  output logic [31:0]       adc_wdata,
  output logic              adc_we,
  output logic              busy,
  output logic              done
);

  typedef enum logic {IDLE, CAPTURE} state_t;

  // Word count is one bit wider than the address so DEPTH itself is representable.
  localparam logic [ADDR_W:0] CNT_END = (ADDR_W+1)'(DEPTH);

  state_t            state, state_nxt;
  logic [11:0]       s0, s1;
  logic [DEC_W-1:0]  dec, dcnt;
  logic [ADDR_W:0]   cnt;
  logic              fin;

  // All DEPTH words issued; the capture closes on the edge after the last write.
  assign fin = (cnt == CNT_END);

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state: start only in IDLE, abort/completion only in CAPTURE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (csr_start_in)        state_nxt = CAPTURE;
      CAPTURE: if (csr_abort_in || fin) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: input registers, decimation, write strobe/address/data, status
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s0        <= '0;
      s1        <= '0;
      dec       <= '0;
      dcnt      <= '0;
      cnt       <= '0;
      adc_addr  <= BASE_ADDR;
      adc_wdata <= '0;
      adc_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      s0 <= ad9238_data_ch0;
      s1 <= ad9238_data_ch1;
      case (state)
        IDLE: begin
          adc_we   <= 1'b0;
          adc_addr <= BASE_ADDR;
          if (csr_start_in) begin
            dec  <= csr_decim_in;
            dcnt <= '0;
            cnt  <= '0;
            busy <= 1'b1;
            done <= 1'b0;
          end
        end
        CAPTURE: begin
          if (csr_abort_in) begin
            // abort wins over a write due on this edge; done stays clear
            adc_we   <= 1'b0;
            busy     <= 1'b0;
            adc_addr <= BASE_ADDR;
          end else if (fin) begin
            adc_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            adc_addr <= BASE_ADDR;
          end else if (dcnt == '0) begin
            adc_we    <= 1'b1;
            adc_wdata <= {4'h0, s1, 4'h0, s0};
            adc_addr  <= BASE_ADDR + cnt[ADDR_W-1:0];
            cnt       <= cnt + 1'b1;
            dcnt      <= dec;
          end else begin
            adc_we <= 1'b0;
            dcnt   <= dcnt - 1'b1;
          end
        end
        default: adc_we <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: directed sequence with random ADC data, checked against a
// timing-arithmetic model (write i lands after edge k+1+i*(dec+1)).
module tb_adc_capture_ctrl;

  localparam int          ADDR_W = 13;
  localparam logic [12:0] BASE   = 13'h0400;
  localparam int          DEPTH  = 1024;
  localparam int          DEC_W  = 8;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic              csr_start_in, csr_abort_in;
  logic [DEC_W-1:0]  csr_decim_in;
  logic [11:0]       ad9238_data_ch0, ad9238_data_ch1;
  logic [ADDR_W-1:0] adc_addr;
  logic [31:0]       adc_wdata;
  logic              adc_we, busy, done;

  adc_capture_ctrl #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .DEPTH(DEPTH), .DEC_W(DEC_W)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .csr_start_in(csr_start_in), .csr_abort_in(csr_abort_in), .csr_decim_in(csr_decim_in),
    .ad9238_data_ch0(ad9238_data_ch0), .ad9238_data_ch1(ad9238_data_ch1),
    .adc_addr(adc_addr), .adc_wdata(adc_wdata), .adc_we(adc_we), .busy(busy), .done(done)
  );

  always #5 sys_clk = ~sys_clk;

  int nvec = 0, nbad = 0;

  // reference model state
  int          e = 0, k = 0, d = 0, nw = 0, obs_wr = 0;
  bit          act = 0, done_m = 0, just_done = 0;
  bit          ewe = 0;
  logic [12:0] ea = BASE;
  logic [31:0] ed = '0;
  logic [23:0] prev = '0, cur;
  bit          ramp = 0, first_pending = 0;
  logic [11:0] rc0, rc1;
  logic [7:0]  decim_in = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance model at posedge, check at negedge.
  task automatic step(input logic st, input logic ab);
    int off;
    csr_start_in = st;
    csr_abort_in = ab;
    csr_decim_in = decim_in;
    if (ramp) begin ad9238_data_ch0 = rc0; ad9238_data_ch1 = rc1; end
    else begin ad9238_data_ch0 = 12'($urandom); ad9238_data_ch1 = 12'($urandom); end
    @(posedge sys_clk);
    e++;
    cur = {ad9238_data_ch1, ad9238_data_ch0};
    ewe = 0;
    just_done = 0;
    if (!act) begin
      ea = BASE;
      if (st) begin act = 1; k = e; d = int'(decim_in); done_m = 0; nw = 0; obs_wr = 0; end
    end else if (ab) begin
      act = 0; ea = BASE;
    end else begin
      off = e - k - 1;
      if (off == (DEPTH - 1) * (d + 1) + 1) begin
        act = 0; done_m = 1; ea = BASE; just_done = 1;
      end else if (off % (d + 1) == 0) begin
        ewe = 1;
        ea  = BASE + 13'(off / (d + 1));
        ed  = {4'h0, prev[23:12], 4'h0, prev[11:0]};
        nw++;
      end
    end
    prev = cur;
    if (ramp) begin rc0++; rc1++; end
    @(negedge sys_clk);
    if (adc_we) obs_wr++;
    chk("we", adc_we, ewe);
    chk("busy", busy, act);
    chk("done", done, done_m);
    if (ewe || !act) chk("addr", adc_addr, ea);
    if (ewe) chk("wdata", adc_wdata, ed);
    if (ewe && first_pending) begin
      chk("ramp_first", adc_wdata, 32'h0555_0AAA);
      first_pending = 0;
    end
    if (just_done) chk("wr_count", obs_wr, DEPTH);
  endtask

  task automatic run_until_idle(input int maxc);
    int n = 0;
    while (act && n < maxc) begin step(0, 0); n++; end
    if (act) begin
      nvec++; nbad++;
      $error("FAIL timeout observed=busy expected=idle within %0d cycles", maxc);
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    csr_start_in = 0; csr_abort_in = 0; csr_decim_in = '0;
    ad9238_data_ch0 = '0; ad9238_data_ch1 = '0;
    #12;
    chk("rst_we", adc_we, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_addr", adc_addr, BASE);
    chk("rst_wdata", adc_wdata, 32'h0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (3) step(0, 0);
    step(0, 1);                              // abort in IDLE ignored

    // ramp capture, decim 0
    ramp = 1; rc0 = 12'hAAA; rc1 = 12'h555; first_pending = 1;
    step(1, 0);
    run_until_idle(DEPTH + 10);
    ramp = 0;
    repeat (3) step(0, 0);

    // decim 3: 1024 writes every 4th cycle
    decim_in = 8'd3;
    step(1, 0);
    run_until_idle(4 * DEPTH + 10);
    repeat (2) step(0, 0);

    // abort after 100 writes, then restart from base
    decim_in = 8'($urandom_range(0, 2));
    step(1, 0);
    for (int i = 0; i < 2000 && nw < 100; i++) step(0, 0);
    step(0, 1);
    repeat (3) step(0, 0);
    decim_in = 8'd0;
    step(1, 0);
    run_until_idle(DEPTH + 10);

    // second start at write 50 ignored
    decim_in = 8'd1;
    step(1, 0);
    for (int i = 0; i < 500 && nw < 50; i++) step(0, 0);
    step(1, 0);
    run_until_idle(2 * DEPTH + 10);
    repeat (2) step(0, 0);

    // start+abort together in IDLE: start wins; decim change mid-capture ignored
    decim_in = 8'd0;
    step(1, 1);
    repeat (10) step(0, 0);
    decim_in = 8'd5;
    run_until_idle(DEPTH + 10);
    step(0, 0);

    // async reset mid-capture
    decim_in = 8'd1;
    step(1, 0);
    repeat (40) step(0, 0);
    @(posedge sys_clk);
    #3 sys_rst_n = 1'b0;
    #1;
    chk("arst_we", adc_we, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_addr", adc_addr, BASE);
    act = 0; done_m = 0; e++;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (6) step(0, 0);
    decim_in = 8'd2;
    step(1, 0);
    run_until_idle(3 * DEPTH + 10);
    step(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
Capture controller between the dual-channel AD9238 input pins and the sample RAM. A one-cycle CSR start pulse triggers a burst capture. The block packs each decimated ch0/ch1 sample pair into one 32-bit word and writes it to consecutive RAM addresses from a fixed base. It reports busy/done and the current write address to the CSR block.

Parameters:
ADDR_W, 13, RAM word-address width
BASE_ADDR, 13'h0400, first write address of every capture
DEPTH, 1024, words written per capture (1..2^ADDR_W-BASE_ADDR)
DEC_W, 8, width of decimation control

Ports:
sys_clk  in  1  system clock (65 MHz)
sys_rst_n  in  1  asynchronous active-low reset
csr_start_in  in  1  single-cycle start pulse, synchronous to sys_clk
csr_abort_in  in  1  single-cycle abort pulse
csr_decim_in  in  DEC_W  decimation: write one sample every csr_decim_in+1 cycles
ad9238_data_ch0  in  12  ADC channel 0 sample
ad9238_data_ch1  in  12  ADC channel 1 sample
adc_addr  out  ADDR_W  RAM write address
adc_wdata  out  32  RAM write data {4'h0, ch1, 4'h0, ch0}
adc_we  out  1  RAM write strobe
busy  out  1  capture in progress
done  out  1  sticky: last capture completed normally

Behaviour:
- One clock domain: sys_clk. Reset is asynchronous and active-low (sys_rst_n). All state and outputs are reset asynchronously.
- Reset values: adc_addr=BASE_ADDR, adc_wdata=0, adc_we=0, busy=0, done=0, FSM=IDLE, sample registers=0.
- Input stage: ch0/ch1 are registered every cycle into s0/s1, unconditionally.
- FSM states: IDLE, CAPTURE.
- IDLE:
  - adc_we=0 and adc_addr=BASE_ADDR.
  - If csr_start_in=1 on edge k: latch dec=csr_decim_in, clear done, set busy, clear word count, set decimation counter=0, go to CAPTURE.
- CAPTURE, on each edge:
  - If decimation counter==0: adc_we<=1, adc_wdata<={4'h0,s1,4'h0,s0}, adc_addr<=BASE_ADDR+count, count++, counter<=dec.
  - Otherwise: adc_we<=0 and counter--.
- Latency: the first adc_we is high in the cycle after edge k+1. Its data is the ADC pins sampled at edge k. adc_addr is valid in the same cycle as adc_we.
- Write spacing is exactly dec+1 cycles. dec=0 gives a write every cycle.
- Completion: when the write for count==DEPTH-1 is issued, at the following edge: adc_we<=0, busy<=0, done<=1, FSM->IDLE, adc_addr<=BASE_ADDR.
- Abort: csr_abort_in=1 in CAPTURE forces at that edge adc_we<=0, busy<=0, done stays 0, FSM->IDLE. Abort takes priority over a same-edge write. Abort in IDLE is ignored.
- csr_start_in while busy=1 is ignored: no restart, count unaffected.
- Start and abort asserted on the same edge in IDLE: start wins. Abort is only evaluated in CAPTURE.
- csr_decim_in changes during CAPTURE have no effect until the next start.
- Address never exceeds BASE_ADDR+DEPTH-1 and never wraps. The count register is ADDR_W+1 bits wide.
- done stays high until the next accepted start or reset.
- Reset asserted mid-capture: outputs return to reset values immediately (asynchronous). No further writes occur.

Test Plan:
- Reset, start at edge k with decim=0, ADC ramp from ch0=12'hAAA/ch1=12'h555 incrementing each cycle -> adc_we high for 1024 consecutive cycles starting after edge k+1. Address 0x0400..0x07FF. First word 32'h0555_0AAA, then each word +0x0001_0001. done=1 and busy=0 one cycle after the last write.
- decim=3 -> writes every 4th cycle. 1024 writes spanning 4093 cycles. Addresses contiguous with no gaps.
- Abort after 100 writes -> adc_we low at that edge, busy=0, done=0, adc_addr=0x0400. A new start then begins again at 0x0400.
- Second start pulse at write 50 -> ignored. Capture still ends after exactly 1024 writes.
- Change csr_decim_in from 0 to 5 mid-capture -> spacing stays 1 cycle. The new value applies only at the next start.
- Assert sys_rst_n low mid-capture, asynchronously between edges -> adc_we, busy, done drop to 0 immediately. adc_addr=0x0400. No writes until a new start.
